// File: rtl/row_buffer_scheduler.sv
// Row buffer sequencer for the 3x3 convolution pipeline: grants buffers to the receiver,
// launches the engine when KERNEL_DIM rows are resident, recycles rows. Option: ROW_LEN_CHECK_EN.
module row_buffer_scheduler #(
  parameter int NUM_BUFS   = 4,
  parameter int PTR_W      = 2,
  parameter int LEN_W      = 12,
  parameter int KERNEL_DIM = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_req,
  output logic             rx_grant,
  output logic [PTR_W-1:0] rx_buf,
  input  logic             rx_done,
  input  logic [LEN_W-1:0] rx_len,
  output logic             proc_start,
  output logic [PTR_W-1:0] proc_top,
  output logic [PTR_W-1:0] proc_mid,
  output logic [PTR_W-1:0] proc_bot,
  output logic [LEN_W-1:0] proc_len,
  input  logic             proc_done,
  input  logic             frame_end,
  output logic             frame_done,
  output logic             busy,
  output logic             err
);
  localparam logic [PTR_W:0]   BUF_CNT  = (PTR_W+1)'(NUM_BUFS);
  localparam logic [PTR_W:0]   KDIM_CNT = (PTR_W+1)'(KERNEL_DIM);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [LEN_W-1:0] EDGE_LEN = LEN_W'(3 * (KERNEL_DIM - 1));
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_TWO  = PTR_W'(2);

  typedef enum logic {RX_IDLE, RX_FILL} rx_state_e;
  typedef enum logic {P_IDLE, P_RUN} p_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  p_state_e         p_state_q, p_state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   rows_valid_q, rows_valid_d;
  logic [LEN_W-1:0] row_len_q, row_len_d;
  logic             first_row_q, first_row_d;
  logic             flush_pend_q, flush_pend_d;
  logic             rx_grant_q, rx_grant_d;
  logic [PTR_W-1:0] rx_buf_q, rx_buf_d;
  logic             proc_start_q, proc_start_d;
  logic [PTR_W-1:0] proc_top_q, proc_top_d;
  logic [PTR_W-1:0] proc_mid_q, proc_mid_d;
  logic [PTR_W-1:0] proc_bot_q, proc_bot_d;
  logic [LEN_W-1:0] proc_len_q, proc_len_d;
  logic             frame_done_q, frame_done_d;
  logic             err_q, err_d;

  logic len_bad;
  logic rx_reject;
  logic rx_accept;
  logic proc_release;
  logic flush_go;

  always_comb begin
    rx_state_d   = rx_state_q;
    p_state_d    = p_state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rows_valid_d = rows_valid_q;
    row_len_d    = row_len_q;
    first_row_d  = first_row_q;
    flush_pend_d = flush_pend_q;
    rx_buf_d     = rx_buf_q;
    proc_top_d   = proc_top_q;
    proc_mid_d   = proc_mid_q;
    proc_bot_d   = proc_bot_q;
    proc_len_d   = proc_len_q;
    rx_grant_d   = 1'b0;
    proc_start_d = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    len_bad = 1'b0;
`ifdef ROW_LEN_CHECK_EN
    len_bad = (rx_len != row_len_q);
`endif
    // A first row must leave at least one output byte after the kernel margin.
    rx_reject    = first_row_q ? (rx_len <= EDGE_LEN) : len_bad;
    rx_accept    = (rx_state_q == RX_FILL) && rx_done && !rx_reject;
    proc_release = (p_state_q == P_RUN) && proc_done;
    flush_go     = flush_pend_q && (rx_state_q == RX_IDLE) && (p_state_q == P_IDLE);

    if (rx_state_q == RX_IDLE) begin
      if (rx_req && (rows_valid_q < BUF_CNT) && !flush_pend_q) begin
        rx_state_d = RX_FILL;
        rx_buf_d   = wr_ptr_q;
        rx_grant_d = 1'b1;
      end
    end else if (rx_done) begin
      rx_state_d = RX_IDLE;
      err_d      = rx_reject;
    end

    if (rx_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (first_row_q) begin
        row_len_d   = rx_len;
        proc_len_d  = rx_len - EDGE_LEN;
        first_row_d = 1'b0;
      end
    end

    if (p_state_q == P_IDLE) begin
      if ((rows_valid_q >= KDIM_CNT) && !flush_pend_q) begin
        p_state_d    = P_RUN;
        proc_top_d   = rd_ptr_q;
        proc_mid_d   = rd_ptr_q + PTR_ONE;
        proc_bot_d   = rd_ptr_q + PTR_TWO;
        proc_start_d = 1'b1;
      end
    end else if (proc_done) begin
      p_state_d = P_IDLE;
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
    end

    // A fill and a release on the same edge cancel out in the resident count.
    case ({rx_accept, proc_release})
      2'b10:   rows_valid_d = rows_valid_q + CNT_ONE;
      2'b01:   rows_valid_d = rows_valid_q - CNT_ONE;
      default: rows_valid_d = rows_valid_q;
    endcase

    if (flush_go) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      rows_valid_d = '0;
      first_row_d  = 1'b1;
      flush_pend_d = 1'b0;
      frame_done_d = 1'b1;
    end else if (frame_end) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= RX_IDLE;
      p_state_q    <= P_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rows_valid_q <= '0;
      row_len_q    <= '0;
      first_row_q  <= 1'b1;
      flush_pend_q <= 1'b0;
      rx_grant_q   <= 1'b0;
      rx_buf_q     <= '0;
      proc_start_q <= 1'b0;
      proc_top_q   <= '0;
      proc_mid_q   <= PTR_ONE;
      proc_bot_q   <= PTR_TWO;
      proc_len_q   <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      p_state_q    <= p_state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rows_valid_q <= rows_valid_d;
      row_len_q    <= row_len_d;
      first_row_q  <= first_row_d;
      flush_pend_q <= flush_pend_d;
      rx_grant_q   <= rx_grant_d;
      rx_buf_q     <= rx_buf_d;
      proc_start_q <= proc_start_d;
      proc_top_q   <= proc_top_d;
      proc_mid_q   <= proc_mid_d;
      proc_bot_q   <= proc_bot_d;
      proc_len_q   <= proc_len_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign rx_grant   = rx_grant_q;
  assign rx_buf     = rx_buf_q;
  assign proc_start = proc_start_q;
  assign proc_top   = proc_top_q;
  assign proc_mid   = proc_mid_q;
  assign proc_bot   = proc_bot_q;
  assign proc_len   = proc_len_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign busy       = (rows_valid_q != '0) || (p_state_q == P_RUN) || (rx_state_q == RX_FILL);

endmodule

// File: tb/tb_row_buffer_scheduler.sv
// Bench for row_buffer_scheduler: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-level model of the buffer ring.
module tb_row_buffer_scheduler;
  localparam int NB   = 4;
  localparam int PW   = 2;
  localparam int LW   = 12;
  localparam int KD   = 3;
  localparam int EDGE = 3 * (KD - 1);
`ifdef ROW_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rx_req = 1'b0;
  logic          rx_done = 1'b0;
  logic [LW-1:0] rx_len = '0;
  logic          proc_done = 1'b0;
  logic          frame_end = 1'b0;
  logic          rx_grant;
  logic [PW-1:0] rx_buf;
  logic          proc_start;
  logic [PW-1:0] proc_top;
  logic [PW-1:0] proc_mid;
  logic [PW-1:0] proc_bot;
  logic [LW-1:0] proc_len;
  logic          frame_done;
  logic          busy;
  logic          err;

  int checks = 0;
  int failures = 0;

  row_buffer_scheduler #(.NUM_BUFS(NB), .PTR_W(PW), .LEN_W(LW), .KERNEL_DIM(KD)) dut (
    .clock(clock), .reset(reset),
    .rx_req(rx_req), .rx_grant(rx_grant), .rx_buf(rx_buf),
    .rx_done(rx_done), .rx_len(rx_len),
    .proc_start(proc_start), .proc_top(proc_top), .proc_mid(proc_mid), .proc_bot(proc_bot),
    .proc_len(proc_len), .proc_done(proc_done),
    .frame_end(frame_end), .frame_done(frame_done), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  // Model: the resident rows are the ring segment starting at m_rd of length m_count.
  bit m_filling, m_running, m_first, m_flush;
  int m_rd, m_count, m_fill_buf, m_row_len, m_proc_len, m_top, m_mid, m_bot;
  bit e_grant, e_start, e_err, e_fdone;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_filling = 0; m_running = 0; m_first = 1; m_flush = 0;
    m_rd = 0; m_count = 0; m_fill_buf = 0; m_row_len = 0; m_proc_len = 0;
    m_top = 0; m_mid = 1; m_bot = 2;
    e_grant = 0; e_start = 0; e_err = 0; e_fdone = 0;
  endtask

  // Everything decided here uses the state as it stood before the clock edge.
  task automatic model_step(input bit req, input bit done, input int len, input bit pdone, input bit fend);
    bit reject;
    bit flush_now;
    int delta;
    delta = 0;
    e_grant = 0; e_start = 0; e_err = 0; e_fdone = 0;
    flush_now = m_flush && !m_filling && !m_running;
    if (!m_filling) begin
      if (req && m_count < NB && !m_flush) begin
        m_filling = 1;
        m_fill_buf = (m_rd + m_count) % NB;
        e_grant = 1;
      end
    end else if (done) begin
      m_filling = 0;
      if (m_first) reject = (len <= EDGE);
      else reject = LEN_CHECK && (len != m_row_len);
      if (reject) e_err = 1;
      else begin
        delta++;
        if (m_first) begin
          m_row_len = len;
          m_proc_len = len - EDGE;
          m_first = 0;
        end
      end
    end
    if (!m_running) begin
      if (m_count >= KD && !m_flush) begin
        m_running = 1;
        m_top = m_rd;
        m_mid = (m_rd + 1) % NB;
        m_bot = (m_rd + 2) % NB;
        e_start = 1;
      end
    end else if (pdone) begin
      m_running = 0;
      m_rd = (m_rd + 1) % NB;
      delta--;
    end
    m_count += delta;
    if (flush_now) begin
      m_rd = 0; m_count = 0; m_first = 1; m_flush = 0; e_fdone = 1;
    end else if (fend) begin
      m_flush = 1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      chk("rx_grant", int'(rx_grant), int'(e_grant));
      chk("rx_buf", int'(rx_buf), m_fill_buf);
      chk("proc_start", int'(proc_start), int'(e_start));
      chk("proc_top", int'(proc_top), m_top);
      chk("proc_mid", int'(proc_mid), m_mid);
      chk("proc_bot", int'(proc_bot), m_bot);
      chk("proc_len", int'(proc_len), m_proc_len);
      chk("frame_done", int'(frame_done), int'(e_fdone));
      chk("err", int'(err), int'(e_err));
      chk("busy", int'(busy), int'(m_count != 0 || m_running || m_filling));
    end
  end

  task automatic drive(input bit req, input bit done, input int len, input bit pdone, input bit fend);
    rx_req = req; rx_done = done; rx_len = LW'(len); proc_done = pdone; frame_end = fend;
    model_step(req, done, len, pdone, fend);
  endtask

  task automatic step(input bit req, input bit done, input int len, input bit pdone, input bit fend);
    @(negedge clock); #1;
    drive(req, done, len, pdone, fend);
  endtask

  task automatic settle();
    @(posedge clock); #2;
  endtask

  task automatic do_reset(input bit check_now);
    @(negedge clock); #1;
    reset = 1'b0;
    rx_req = 0; rx_done = 0; rx_len = '0; proc_done = 0; frame_end = 0;
    model_reset();
    #1;
    if (check_now) begin
      chk("rst_rx_grant", int'(rx_grant), 0);
      chk("rst_rx_buf", int'(rx_buf), 0);
      chk("rst_proc_top", int'(proc_top), 0);
      chk("rst_proc_mid", int'(proc_mid), 1);
      chk("rst_proc_bot", int'(proc_bot), 2);
      chk("rst_proc_len", int'(proc_len), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(err), 0);
    end
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic send_row(input int len, input int exp_buf, input bit exp_err);
    step(1, 0, 0, 0, 0);
    settle();
    chk("grant", int'(rx_grant), 1);
    chk("grant_buf", int'(rx_buf), exp_buf);
    step(0, 1, len, 0, 0);
    settle();
    chk("row_err", int'(err), int'(exp_err));
    $display("row len=%0d buf=%0d err=%0d", len, rx_buf, err);
  endtask

  task automatic rand_cycle();
    int len;
    bit req, done, pdone, fend;
    @(negedge clock); #1;
    req   = ($urandom_range(3) != 0);
    done  = m_filling ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
    pdone = m_running ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
    fend  = ($urandom_range(59) == 0);
    if ($urandom_range(7) == 0) len = int'($urandom_range(40));
    else len = m_first ? 30 : m_row_len;
    drive(req, done, len, pdone, fend);
  endtask

  initial begin
    model_reset();
    do_reset(1'b0);

    // Three rows, first engine launch on buffers 0/1/2.
    send_row(30, 0, 0);
    send_row(30, 1, 0);
    send_row(30, 2, 0);
    step(0, 0, 0, 0, 0);
    settle();
    chk("start1", int'(proc_start), 1);
    chk("start1_top", int'(proc_top), 0);
    chk("start1_mid", int'(proc_mid), 1);
    chk("start1_bot", int'(proc_bot), 2);
    chk("start1_len", int'(proc_len), 24);
    chk("model_len", m_proc_len, 24);

    // Fourth row during processing; fifth must wait for a release.
    send_row(30, 3, 0);
    step(1, 0, 0, 0, 0);
    settle();
    chk("full_no_grant", int'(rx_grant), 0);
    step(1, 0, 0, 1, 0);
    settle();
    chk("release_no_grant", int'(rx_grant), 0);
    step(1, 0, 0, 0, 0);
    settle();
    chk("regrant", int'(rx_grant), 1);
    chk("regrant_buf", int'(rx_buf), 0);
    chk("start2", int'(proc_start), 1);
    chk("start2_top", int'(proc_top), 1);
    chk("start2_bot", int'(proc_bot), 3);
    $display("start top=%0d mid=%0d bot=%0d", proc_top, proc_mid, proc_bot);

    // Simultaneous fill completion and release.
    step(0, 1, 30, 1, 0);
    settle();
    chk("simul_busy", int'(busy), 1);
    step(0, 0, 0, 0, 0);
    settle();
    chk("start3", int'(proc_start), 1);
    chk("start3_top", int'(proc_top), 2);
    chk("start3_bot", int'(proc_bot), 0);
    step(1, 0, 0, 0, 0);
    settle();
    chk("grant_after_simul", int'(rx_buf), 1);

    // Reset in the middle of a fill.
    do_reset(1'b1);

    // Short first row rejected, buffer 0 granted again.
    send_row(6, 0, 1);
    chk("short_busy", int'(busy), 0);
    send_row(30, 0, 0);
    send_row(27, 1, LEN_CHECK);
    send_row(30, LEN_CHECK ? 1 : 2, 0);

    // Frame end with two rows resident.
    do_reset(1'b0);
    send_row(30, 0, 0);
    send_row(30, 1, 0);
    step(0, 0, 0, 0, 1);
    settle();
    chk("flush_wait", int'(frame_done), 0);
    chk("flush_busy", int'(busy), 1);
    step(0, 0, 0, 0, 0);
    settle();
    chk("frame_done", int'(frame_done), 1);
    chk("flush_no_start", int'(proc_start), 0);
    chk("flush_idle", int'(busy), 0);
    $display("frame flushed");
    send_row(30, 0, 0);

    // Randomized traffic.
    do_reset(1'b0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(499) == 0) do_reset(1'b0);
      else rand_cycle();
    end
    @(negedge clock); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
